// File: rtl/apple_ctrl.sv
// apple_ctrl: per-slot apple trap state machines plus a shared sprite ROM pixel arbiter.
// Optional feature macro APPLE_RESPAWN_EN: GONE slots return to their origin after RESPAWN_TICKS update ticks.
module apple_ctrl #(
  parameter int unsigned N_APPLES      = 4,
  parameter int unsigned APPLE_W       = 22,
  parameter int unsigned APPLE_H       = 24,
  parameter int unsigned SCREEN_H      = 600,
  parameter int unsigned STEP          = 1,
  parameter int unsigned RESPAWN_TICKS = 64,
  localparam int unsigned IW = (N_APPLES > 1) ? $clog2(N_APPLES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update_tick,
  input  logic                anim_tick,
  input  logic [9:0]          kid_x,
  input  logic [9:0]          kid_y,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_idx,
  input  logic [9:0]          cfg_x,
  input  logic [9:0]          cfg_y,
  input  logic [9:0]          cfg_trig_dx,
  input  logic                cfg_dir,
  input  logic [9:0]          col,
  input  logic [9:0]          row,
  output logic [10:0]         rom_addr,
  input  logic [11:0]         rom_data,
  output logic                is_apple,
  output logic [11:0]         apple_rgb,
  output logic [N_APPLES-1:0] moving
);

  localparam int unsigned SPRITE_SZ = APPLE_W * APPLE_H;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_MOVING = 2'd2,
    S_GONE   = 2'd3
  } slot_state_e;

  if (N_APPLES < 1 || N_APPLES > 8 || RESPAWN_TICKS < 1) begin : g_param_check
    $error("apple_ctrl: N_APPLES must be 1..8 and RESPAWN_TICKS at least 1");
  end

  slot_state_e state_q [N_APPLES];
  slot_state_e state_d [N_APPLES];
  logic [9:0]  x_q     [N_APPLES];
  logic [9:0]  x_d     [N_APPLES];
  logic [9:0]  y_q     [N_APPLES];
  logic [9:0]  y_d     [N_APPLES];
  logic [9:0]  tdx_q   [N_APPLES];
  logic [9:0]  tdx_d   [N_APPLES];
  logic        dir_q   [N_APPLES];
  logic        dir_d   [N_APPLES];
  logic        frame_q;

`ifdef APPLE_RESPAWN_EN
  localparam int unsigned CNT_W = $clog2(RESPAWN_TICKS + 1);
  logic [9:0]       org_x_q [N_APPLES];
  logic [9:0]       org_x_d [N_APPLES];
  logic [9:0]       org_y_q [N_APPLES];
  logic [9:0]       org_y_d [N_APPLES];
  logic [CNT_W-1:0] cnt_q   [N_APPLES];
  logic [CNT_W-1:0] cnt_d   [N_APPLES];
`endif

  logic [9:0]          dx_c [N_APPLES];
  logic [9:0]          dy_c [N_APPLES];
  logic                hit_c;
  logic [10:0]         addr_c;
  logic [N_APPLES-1:0] moving_c;
  logic                hit_d1;
  logic                hit_d2;

  // State register: slot state, slot position/config and the shared frame bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 1'b0;
      for (int i = 0; i < int'(N_APPLES); i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        tdx_q[i]   <= '0;
        dir_q[i]   <= 1'b0;
`ifdef APPLE_RESPAWN_EN
        org_x_q[i] <= '0;
        org_y_q[i] <= '0;
        cnt_q[i]   <= '0;
`endif
      end
    end else begin
      frame_q <= frame_q ^ anim_tick;
      for (int i = 0; i < int'(N_APPLES); i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        tdx_q[i]   <= tdx_d[i];
        dir_q[i]   <= dir_d[i];
`ifdef APPLE_RESPAWN_EN
        org_x_q[i] <= org_x_d[i];
        org_y_q[i] <= org_y_d[i];
        cnt_q[i]   <= cnt_d[i];
`endif
      end
    end
  end

  // Next-state: a config write overrides everything else for its slot.
  always_comb begin
    for (int i = 0; i < int'(N_APPLES); i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      tdx_d[i]   = tdx_q[i];
      dir_d[i]   = dir_q[i];
`ifdef APPLE_RESPAWN_EN
      org_x_d[i] = org_x_q[i];
      org_y_d[i] = org_y_q[i];
      cnt_d[i]   = cnt_q[i];
`endif
    end
    for (int i = 0; i < int'(N_APPLES); i++) begin
      if (cfg_we && (cfg_idx == IW'(i))) begin
        state_d[i] = S_ARMED;
        x_d[i]     = cfg_x;
        y_d[i]     = cfg_y;
        tdx_d[i]   = cfg_trig_dx;
        dir_d[i]   = cfg_dir;
`ifdef APPLE_RESPAWN_EN
        org_x_d[i] = cfg_x;
        org_y_d[i] = cfg_y;
        cnt_d[i]   = '0;
`endif
      end else begin
        unique case (state_q[i])
          S_ARMED: begin
            if ((kid_x == 10'(x_q[i] + tdx_q[i])) &&
                (dir_q[i] ? (kid_y < y_q[i]) : (kid_y > y_q[i]))) begin
              state_d[i] = S_MOVING;
            end
          end
          S_MOVING: begin
            if (update_tick) begin
              if (!dir_q[i]) begin
                if (({1'b0, y_q[i]} + 11'(STEP)) >= 11'(SCREEN_H)) state_d[i] = S_GONE;
                else                                                y_d[i]     = y_q[i] + 10'(STEP);
              end else begin
                if (y_q[i] < 10'(STEP)) state_d[i] = S_GONE;
                else                    y_d[i]     = y_q[i] - 10'(STEP);
              end
            end
          end
`ifdef APPLE_RESPAWN_EN
          S_GONE: begin
            if (update_tick) begin
              if ((32'(cnt_q[i]) + 32'd1) >= RESPAWN_TICKS) begin
                state_d[i] = S_ARMED;
                x_d[i]     = org_x_q[i];
                y_d[i]     = org_y_q[i];
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i]   = cnt_q[i] + CNT_W'(1);
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Output decode: lowest-index visible slot under the scan pixel owns the ROM.
  always_comb begin
    hit_c    = 1'b0;
    addr_c   = '0;
    moving_c = '0;
    for (int i = 0; i < int'(N_APPLES); i++) begin
      dx_c[i]     = col - x_q[i];
      dy_c[i]     = row - y_q[i];
      moving_c[i] = (state_d[i] == S_MOVING);
    end
    for (int i = int'(N_APPLES) - 1; i >= 0; i--) begin
      if (((state_q[i] == S_ARMED) || (state_q[i] == S_MOVING)) &&
          (dx_c[i] < 10'(APPLE_W)) && (dy_c[i] < 10'(APPLE_H))) begin
        hit_c  = 1'b1;
        addr_c = 11'(dx_c[i]) + 11'(dy_c[i]) * 11'(APPLE_W) +
                 (frame_q ? 11'(SPRITE_SZ) : 11'd0);
      end
    end
  end

  // Pixel pipeline: address at t+1, colour qualified by the ROM word and the twice-delayed hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      is_apple  <= 1'b0;
      apple_rgb <= '0;
      moving    <= '0;
    end else begin
      rom_addr  <= addr_c;
      hit_d1    <= hit_c;
      hit_d2    <= hit_d1;
      is_apple  <= hit_d2 && (rom_data != 12'hFFF);
      apple_rgb <= (hit_d2 && (rom_data != 12'hFFF)) ? rom_data : 12'h000;
      moving    <= moving_c;
    end
  end

endmodule
